cmd_dispatcher: RTL and testbench

CMD_DISPATCHER -- requirements
Module: cmd_dispatcher

---
 rtl/osc_cmd_pkg.sv | 32 +++
 rtl/cmd_tx_mux.sv | 53 +++++
 rtl/cmd_dispatcher.sv | 186 ++++++++++++++++++
 tb/tb_cmd_dispatcher.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/osc_cmd_pkg.sv
// rtl/osc_cmd_pkg.sv - shared command codes and dispatcher state encoding
package osc_cmd_pkg;

    // Dispatcher FSM state encoding
    typedef enum logic [1:0] {
        DISP_IDLE   = 2'd0,
        DISP_ACTIVE = 2'd1,
        DISP_DRAIN  = 2'd2
    } disp_state_e;

    // Plain-vector aliases of the state encoding for legacy consumers
    localparam logic [1:0] ST_IDLE   = 2'(DISP_IDLE);
    localparam logic [1:0] ST_ACTIVE = 2'(DISP_ACTIVE);
    localparam logic [1:0] ST_DRAIN  = 2'(DISP_DRAIN);

    // Default command codes of the oscilloscope firmware handlers
    localparam logic [7:0] CMD_TEST        = 8'h11;
    localparam logic [7:0] CMD_SAMPLER     = 8'h21;
    localparam logic [7:0] CMD_SAMPLE_READ = 8'h22;
    localparam logic [7:0] CMD_REPLAYER    = 8'h71;
    localparam logic [7:0] CMD_REPLY_CNT   = 8'h72;

    // Display codes that never select a handler
    localparam logic [7:0] CODE_NONE  = 8'h00;
    localparam logic [7:0] CODE_DRAIN = 8'h01;

    // Reserved codes are shown on the display, so they can never be commands
    function automatic logic is_reserved_code(input logic [7:0] code);
        return (code == CODE_NONE) || (code == CODE_DRAIN);
    endfunction

endpackage

// File: rtl/cmd_tx_mux.sv
// rtl/cmd_tx_mux.sv - registered one-hot mux of handler TX byte/start onto the UART
module cmd_tx_mux #(
    parameter int N_HANDLERS = 4,
    parameter int DATA_W     = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         en_i,
    input  logic [N_HANDLERS-1:0]        sel_i,
    input  logic [N_HANDLERS*DATA_W-1:0] src_data_i,
    input  logic [N_HANDLERS-1:0]        src_start_i,
    output logic [DATA_W-1:0]            tx_data_o,
    output logic                         tx_start_o
);

    logic [DATA_W-1:0] mux_data;
    logic              mux_start;
    logic [DATA_W-1:0] tx_data_d,  tx_data_q;
    logic              tx_start_d, tx_start_q;

    // AND-OR mux: sel_i is one-hot or zero, so OR-ing the enabled lanes is exact
    always_comb begin
        mux_data  = '0;
        mux_start = 1'b0;
        for (int k = 0; k < N_HANDLERS; k++) begin
            if (sel_i[k]) begin
                mux_data  = mux_data | src_data_i[k*DATA_W +: DATA_W];
                mux_start = mux_start | src_start_i[k];
            end
        end
    end

    // Outside the enable window the byte is held and start is forced low
    always_comb begin
        tx_data_d  = en_i ? mux_data : tx_data_q;
        tx_start_d = en_i & mux_start;
    end

    // Output registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
        end else begin
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
        end
    end

    assign tx_data_o  = tx_data_q;
    assign tx_start_o = tx_start_q;

endmodule

// File: rtl/cmd_dispatcher.sv
// rtl/cmd_dispatcher.sv - UART command decoder/dispatcher FSM; watchdog via CMD_DISPATCH_TIMEOUT_EN
module cmd_dispatcher
    import osc_cmd_pkg::*;
#(
    parameter int                      N_HANDLERS     = 4,
    parameter logic [N_HANDLERS*8-1:0] CMD_CODES      = {CMD_REPLY_CNT, CMD_REPLAYER, CMD_SAMPLER, CMD_TEST},
    parameter int                      DATA_W         = 8,
    parameter int                      TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rx_ready,
    input  logic [DATA_W-1:0]            rx_data,
    input  logic                         tx_active,
    input  logic [N_HANDLERS-1:0]        handler_done,
    input  logic [N_HANDLERS*DATA_W-1:0] handler_tx_data,
    input  logic [N_HANDLERS-1:0]        handler_tx_start,
    output logic [N_HANDLERS-1:0]        handler_activate,
    output logic [DATA_W-1:0]            tx_data,
    output logic                         tx_start,
    output logic [7:0]                   state_code,
    output logic                         busy,
    output logic                         err_unknown
`ifdef CMD_DISPATCH_TIMEOUT_EN
    ,
    output logic                         timeout
`endif
);

    localparam int IDX_W = (N_HANDLERS > 1) ? $clog2(N_HANDLERS) : 1;

    logic [1:0]            state_d, state_q;
    logic [N_HANDLERS-1:0] act_d, act_q;
    logic [7:0]            code_d, code_q;
    logic                  busy_d, busy_q;
    logic                  err_d, err_q;

    logic                  hit;
    logic [IDX_W-1:0]      hit_idx;
    logic [7:0]            rx_code;
    logic                  done_sel;

    assign rx_code  = 8'(rx_data);
    assign done_sel = |(handler_done & act_q);

`ifdef CMD_DISPATCH_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [WD_W-1:0] wd_d, wd_q;
    logic            wd_hit;
    logic            timeout_d, timeout_q;

    assign wd_hit = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`endif

    // Command decode: scan high-to-low so a duplicated code resolves to the lowest index
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = N_HANDLERS - 1; k >= 0; k--) begin
            if (rx_data == DATA_W'(CMD_CODES[k*8 +: 8])) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(k);
            end
        end
        if (is_reserved_code(rx_code)) begin
            hit = 1'b0;
        end
    end

    // Dispatcher next-state: IDLE decodes, ACTIVE waits for the owner, DRAIN waits for a quiet UART
    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        code_d  = code_q;
        err_d   = 1'b0;
`ifdef CMD_DISPATCH_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rx_ready) begin
                    if (hit) begin
                        state_d        = ST_ACTIVE;
                        act_d          = '0;
                        act_d[hit_idx] = 1'b1;
                        code_d         = rx_code;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                if (done_sel) begin
                    state_d = ST_DRAIN;
                    act_d   = '0;
                    code_d  = CODE_DRAIN;
                end
`ifdef CMD_DISPATCH_TIMEOUT_EN
                else if (wd_hit) begin
                    state_d   = ST_DRAIN;
                    act_d     = '0;
                    code_d    = CODE_DRAIN;
                    timeout_d = 1'b1;
                end
`endif
            end
            ST_DRAIN: begin
                // Bytes arriving here belong to the finished command and are dropped silently
                if (!rx_ready && !tx_active) begin
                    state_d = ST_IDLE;
                    code_d  = CODE_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                act_d   = '0;
                code_d  = CODE_NONE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

`ifdef CMD_DISPATCH_TIMEOUT_EN
    // Watchdog counts consecutive ACTIVE cycles and restarts from zero on every entry
    always_comb begin
        if (state_q == ST_ACTIVE && state_d == ST_ACTIVE) begin
            wd_d = wd_q + WD_W'(1);
        end else begin
            wd_d = '0;
        end
    end

    // Watchdog registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`endif

    // FSM and registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            act_q   <= '0;
            code_q  <= CODE_NONE;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            code_q  <= code_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // The mux samples during every ACTIVE cycle, so a byte started on the
    // handler's final cycle still reaches the UART on the first DRAIN cycle
    cmd_tx_mux #(
        .N_HANDLERS (N_HANDLERS),
        .DATA_W     (DATA_W)
    ) u_tx_mux (
        .clk_i       (clk),
        .rst_n_i     (reset),
        .en_i        (state_q == ST_ACTIVE),
        .sel_i       (act_q),
        .src_data_i  (handler_tx_data),
        .src_start_i (handler_tx_start),
        .tx_data_o   (tx_data),
        .tx_start_o  (tx_start)
    );

    assign handler_activate = act_q;
    assign state_code       = code_q;
    assign busy             = busy_q;
    assign err_unknown      = err_q;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// tb/tb_cmd_dispatcher.sv - directed self-checking bench for cmd_dispatcher
module tb_cmd_dispatcher;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        tx_active;
    logic [3:0]  handler_done;
    logic [31:0] handler_tx_data;
    logic [3:0]  handler_tx_start;
    logic [3:0]  handler_activate;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic [7:0]  state_code;
    logic        busy;
    logic        err_unknown;
`ifdef CMD_DISPATCH_TIMEOUT_EN
    logic        timeout;
`endif

    int pass_cnt  = 0;
    int check_cnt = 0;
    logic [7:0] tx_q[$];

    cmd_dispatcher #(
        .N_HANDLERS     (4),
        .CMD_CODES      ({8'h72, 8'h71, 8'h21, 8'h11}),
        .DATA_W         (8),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .rx_ready         (rx_ready),
        .rx_data          (rx_data),
        .tx_active        (tx_active),
        .handler_done     (handler_done),
        .handler_tx_data  (handler_tx_data),
        .handler_tx_start (handler_tx_start),
        .handler_activate (handler_activate),
        .tx_data          (tx_data),
        .tx_start         (tx_start),
        .state_code       (state_code),
        .busy             (busy),
        .err_unknown      (err_unknown)
`ifdef CMD_DISPATCH_TIMEOUT_EN
        ,
        .timeout          (timeout)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock, sample 1ns after the edge, and retire any UART byte against the scoreboard
    task automatic tick();
        logic [7:0] exp_b;
        @(posedge clk);
        #1;
        if (tx_start === 1'b1) begin
            check("tx_pending", 32'(tx_q.size() > 0), 32'd1);
            if (tx_q.size() > 0) begin
                exp_b = tx_q.pop_front();
                check("tx_data", 32'(tx_data), 32'(exp_b));
            end
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_ready = 1'b1;
        rx_data  = b;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_act"},  32'(handler_activate), 32'h0);
        check({tag, "_code"}, 32'(state_code),       32'h0);
        check({tag, "_busy"}, 32'(busy),             32'h0);
        check({tag, "_err"},  32'(err_unknown),      32'h0);
        check({tag, "_txs"},  32'(tx_start),         32'h0);
        check({tag, "_txd"},  32'(tx_data),          32'h0);
`ifdef CMD_DISPATCH_TIMEOUT_EN
        check({tag, "_tmo"},  32'(timeout),          32'h0);
`endif
    endtask

    initial begin
        logic [7:0] bad_codes [3];
        int         bad_cycles;

        bad_codes = '{8'h55, 8'h00, 8'h01};

        reset            = 1'b0;
        rx_ready         = 1'b0;
        rx_data          = 8'h00;
        tx_active        = 1'b0;
        handler_done     = 4'h0;
        handler_tx_data  = 32'h0;
        handler_tx_start = 4'h0;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("post_reset_busy", 32'(busy), 32'h0);

        // 8'h71 selects handler 2
        send_rx(8'h71);
        check("act71_act",  32'(handler_activate), 32'h4);
        check("act71_code", 32'(state_code),       32'h71);
        check("act71_busy", 32'(busy),             32'h1);
        check("act71_err",  32'(err_unknown),      32'h0);

        // Bytes and foreign done strobes are ignored while ACTIVE
        send_rx(8'h11);
        check("active_rx_ign_act", 32'(handler_activate), 32'h4);
        check("active_rx_ign_err", 32'(err_unknown),      32'h0);
        handler_done = 4'b0001;
        tick();
        handler_done = 4'h0;
        check("foreign_done_act", 32'(handler_activate), 32'h4);

        // Owner finishes while the UART is still busy: DRAIN for 10 cycles
        tx_active    = 1'b1;
        handler_done = 4'b0100;
        tick();
        handler_done = 4'h0;
        check("drain_code", 32'(state_code),       32'h01);
        check("drain_act",  32'(handler_activate), 32'h0);
        check("drain_busy", 32'(busy),             32'h1);
        bad_cycles = 0;
        for (int i = 0; i < 9; i++) begin
            rx_ready = (i == 3);
            rx_data  = 8'h55;
            tick();
            if (state_code !== 8'h01 || err_unknown !== 1'b0) bad_cycles++;
        end
        rx_ready = 1'b0;
        check("drain_hold", 32'(bad_cycles), 32'h0);
        tx_active = 1'b0;
        tick();
        check("drain_exit_code", 32'(state_code), 32'h00);
        check("drain_exit_busy", 32'(busy),       32'h0);

        // Unmatched and reserved bytes pulse err_unknown for exactly one cycle
        for (int i = 0; i < 3; i++) begin
            send_rx(bad_codes[i]);
            check("unk_err",  32'(err_unknown),      32'h1);
            check("unk_act",  32'(handler_activate), 32'h0);
            check("unk_busy", 32'(busy),             32'h0);
            tick();
            check("unk_err_clr", 32'(err_unknown), 32'h0);
        end

        // 8'h72 selects handler 3; only its TX lane reaches the UART
        send_rx(8'h72);
        check("act72_act",  32'(handler_activate), 32'h8);
        check("act72_code", 32'(state_code),       32'h72);
        handler_tx_data  = {8'hA5, 8'h00, 8'h3C, 8'h00};
        handler_tx_start = 4'b1010;
        handler_done     = 4'b0001;
        tx_q.push_back(8'hA5);
        tick();
        check("mux_start", 32'(tx_start), 32'h1);
        handler_tx_start = 4'h0;
        handler_done     = 4'h0;
        tick();
        check("mux_start_clr", 32'(tx_start),         32'h0);
        check("mux_data_hold", 32'(tx_data),          32'hA5);
        check("act72_kept",    32'(handler_activate), 32'h8);
        handler_done = 4'b1000;
        tick();
        handler_done = 4'h0;
        check("act72_drain", 32'(state_code), 32'h01);
        tick();
        check("act72_idle",     32'(state_code), 32'h00);
        check("idle_data_hold", 32'(tx_data),    32'hA5);
        check("idle_start",     32'(tx_start),   32'h0);

        // Reset asserted mid-command clears everything without a clock edge
        send_rx(8'h11);
        check("act11_act", 32'(handler_activate), 32'h1);
        handler_tx_data  = 32'h0000_005A;
        handler_tx_start = 4'b0001;
        tx_q.push_back(8'h5A);
        tick();
        handler_tx_start = 4'h0;
        check("act11_txs", 32'(tx_start), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("rst_release_busy", 32'(busy), 32'h0);

        // Fresh command after reset proves the FSM is back in IDLE
        send_rx(8'h21);
        check("act21_act",  32'(handler_activate), 32'h2);
        check("act21_code", 32'(state_code),       32'h21);
        bad_cycles = 0;
`ifdef CMD_DISPATCH_TIMEOUT_EN
        for (int i = 1; i < 100; i++) begin
            tick();
            if (handler_activate !== 4'h2 || timeout !== 1'b0) bad_cycles++;
        end
        check("wd_quiet", 32'(bad_cycles), 32'h0);
        tick();
        check("wd_timeout", 32'(timeout),          32'h1);
        check("wd_drain",   32'(state_code),       32'h01);
        check("wd_act",     32'(handler_activate), 32'h0);
        tick();
        check("wd_pulse_end", 32'(timeout),    32'h0);
        check("wd_idle",      32'(state_code), 32'h00);
`else
        for (int i = 0; i < 120; i++) begin
            tick();
            if (handler_activate !== 4'h2 || busy !== 1'b1) bad_cycles++;
        end
        check("no_wd_stay", 32'(bad_cycles), 32'h0);
        handler_done = 4'b0010;
        tick();
        handler_done = 4'h0;
        check("no_wd_drain", 32'(state_code), 32'h01);
        tick();
        check("no_wd_idle", 32'(state_code), 32'h00);
`endif

        check("sb_empty", 32'(tx_q.size()), 32'h0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
